spi_master_seq: RTL and testbench
=================================

// Module: spi_master_seq
// PURPOSE
//  Sequences SPI frames into the SPI wrapper (slave + RAM) on behalf of one on-chip requester.
//  Converts valid/ready op+byte requests into framed MOSI/SS_n bit streams, samples MISO for read-data ops.
//  Returns read bytes on a one-cycle rsp pulse.
//  Sits between the system-side requester and the wrapper's MOSI/MISO/SS_n pins, same clock domain.
// PARAMETERS
//  DATA_W   8  payload width (bits per frame after command)
//  CMD_W    2  command field width
//  RD_TURN  2  cycles between last MOSI bit and first MISO sample on RD_DATA frames
//  GAP      1  minimum cycles SS_n held high between frames (>=1)
// PORTS
//  clk        in   1       system clock; all logic posedge
//  rst_n      in   1       async active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept request
//  req_op     in   CMD_W   00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//  req_data   in   DATA_W  address/data byte (ignored for RD_DATA, MOSI payload sent as 0)
//  rsp_valid  out  1       one-cycle pulse, read byte valid
//  rsp_data   out  DATA_W  read byte, held until next rsp_valid
//  err        out  1       one-cycle pulse, request rejected (SEQ_CHECK only)
//  busy       out  1       frame in progress or gap pending
//  SS_n       out  1       slave select, active low
//  MOSI       out  1       serial data to wrapper, registered
//  MISO       in   1       serial data from wrapper
// BEHAVIOUR
//  - Reset (async): SS_n=1, MOSI=0, req_ready=0 during reset then 1, rsp_valid=0, rsp_data=0, err=0, busy=0, state IDLE.
//  - Handshake: accept when req_valid&&req_ready; ready=1 only in IDLE; op/data latched on accept; ready drops next cycle.
//  - FSM: IDLE -> SHIFT -> (RD_DATA ? TURN -> RECV) -> GAP -> IDLE.
//  - SHIFT: starts cycle after accept; SS_n=0; MOSI registered; 1+CMD_W+DATA_W = 11 bits, one per clk:
//    bit0 = op[1] (rd/wr flag), then op[1],op[0], then data MSB first.
//  - TURN: RD_TURN cycles, SS_n=0, MOSI=0.
//  - RECV: DATA_W cycles, SS_n=0, sample MISO each posedge MSB first into shift reg.
//  - GAP: SS_n=1, MOSI=0 for GAP cycles; rsp_valid pulses on first GAP cycle for RD_DATA with rsp_data updated same cycle.
//  - SS_n low length: 11 cycles writes/RD_ADDR; 11+RD_TURN+8 for RD_DATA.
//  - Accept-to-rsp_valid latency on RD_DATA: 1+11+RD_TURN+8 cycles (=22 at defaults).
//  - Back-to-back: next accept possible in last GAP cycle (req_ready combinational on GAP-done), so SS_n high exactly GAP cycles.
//  - busy = (state != IDLE).
//  - Bit/turn counters saturate-free: 4-bit counter reloaded per state, never wraps past its terminal count.
//  - req_valid while busy: held by requester, no effect. MISO ignored outside RECV.
//  - Reset mid-frame: SS_n -> 1 immediately, partial frame abandoned, no rsp_valid, rd-addr flag cleared.
// CONFIGURATION
//  SPI_MASTER_SEQ_CHECK_EN defined: tracks rd_addr_pending flag (set on RD_ADDR frame completion, cleared on RD_DATA).
//    RD_DATA with flag clear -> accepted, no frame, err pulses cycle after accept, back to IDLE.
//  Not defined: no tracking, err tied 0, every op framed.
// STRUCTURE
//  spi_master_seq_pkg: op_e enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), state_e enum (IDLE, SHIFT, TURN, RECV, GAP),
//    FRAME_BITS = 1+CMD_W+DATA_W localparam.
//  Sub-module spi_master_shreg: 11-bit parallel-in/serial-out for MOSI + DATA_W serial-in/parallel-out for MISO,
//    load/shift/capture enables from FSM.
// TESTING
//  WR_ADDR 0x3C -> SS_n low 11 cycles, MOSI = 0,0,0,0,0,1,1,1,1,0,0, then SS_n high 1 cycle, no rsp.
//  RD_ADDR 0x10 then RD_DATA, wrapper model drives 0xA5 -> rsp_valid once, rsp_data=0xA5, 22 cycles after RD_DATA accept.
//  Back-to-back WR_ADDR/WR_DATA with req_valid held -> SS_n high exactly GAP=1 cycle between frames.
//  rst_n low at bit 5 of SHIFT -> SS_n=1 same cycle, no rsp_valid, req_ready=1 after release.
//  SEQ_CHECK_EN: RD_DATA first after reset -> err pulse, SS_n stays 1; without macro -> full 21-cycle frame.
//  MISO toggling outside RECV -> rsp_data unchanged.

Source files
------------

// File: rtl/spi_master_seq_pkg.sv
// rtl/spi_master_seq_pkg.sv - shared widths, opcode/state enums and frame builder for spi_master_seq
package spi_master_seq_pkg;

    localparam int DATA_W          = 8;
    localparam int CMD_W           = 2;
    localparam int RD_TURN_DEFAULT = 2;
    localparam int GAP_DEFAULT     = 1;
    localparam int FRAME_BITS      = 1 + CMD_W + DATA_W;

    typedef enum logic [CMD_W-1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_TURN,
        ST_RECV,
        ST_GAP
    } state_e;

    // Leading bit repeats the rd/wr flag so the slave can decode direction on the first clock.
    function automatic logic [FRAME_BITS-1:0] build_frame(input op_e op, input logic [DATA_W-1:0] data);
        return {op[CMD_W-1], op, data};
    endfunction

endpackage

// File: rtl/spi_master_seq_if.sv
// rtl/spi_master_seq_if.sv - requester-side request/response bundle for spi_master_seq
interface spi_master_seq_if;
    import spi_master_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [CMD_W-1:0]  req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              err;
    logic              busy;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data, err, busy
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data, err, busy
    );

endinterface

// File: rtl/spi_master_shreg.sv
// rtl/spi_master_shreg.sv - MOSI parallel-in/serial-out and MISO serial-in/parallel-out shift registers
module spi_master_shreg
    import spi_master_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  clear,
    input  logic                  capture,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  miso,
    output logic                  mosi,
    output logic [DATA_W-1:0]     rx_next
);

    logic [FRAME_BITS-1:0] tx;
    logic [DATA_W-2:0]     rx;

    // Only DATA_W-1 bits are stored; the final MISO bit goes straight into rx_next.
    assign rx_next = {rx, miso};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx   <= '0;
            rx   <= '0;
            mosi <= 1'b0;
        end else begin
            if (load) begin
                mosi <= frame[FRAME_BITS-1];
                tx   <= {frame[FRAME_BITS-2:0], 1'b0};
            end else if (shift) begin
                mosi <= tx[FRAME_BITS-1];
                tx   <= {tx[FRAME_BITS-2:0], 1'b0};
            end else if (clear) begin
                mosi <= 1'b0;
            end
            if (capture) begin
                rx <= rx_next[DATA_W-2:0];
            end
        end
    end

endmodule

// File: rtl/spi_master_seq.sv
// rtl/spi_master_seq.sv - SPI frame sequencer for one requester; SPI_MASTER_SEQ_CHECK_EN rejects RD_DATA without a prior RD_ADDR
module spi_master_seq
    import spi_master_seq_pkg::*;
#(
    parameter int RD_TURN = RD_TURN_DEFAULT,
    parameter int GAP     = GAP_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_seq_if.slave     bus,
    output logic                SS_n,
    output logic                MOSI,
    input  logic                MISO
);

    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0] TURN_LAST  = 4'(RD_TURN - 1);
    localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

    state_e              state;
    logic [3:0]          cnt;
    op_e                 op_q;
    op_e                 req_op;
    logic                gap_done;
    logic                accept;
    logic                reject;
    logic                frame_load;
    logic [DATA_W-1:0]   payload;
    logic [DATA_W-1:0]   rx_next;

    assign req_op   = op_e'(bus.req_op);
    assign gap_done = (state == ST_GAP) && (cnt == GAP_LAST);
    // Ready in the last GAP cycle lets back-to-back frames keep SS_n high for exactly GAP cycles.
    assign bus.req_ready = rst_n && ((state == ST_IDLE) || gap_done);
    assign accept     = bus.req_valid && bus.req_ready;
    assign frame_load = accept && !reject;
    assign payload    = (req_op == OP_RD_DATA) ? '0 : bus.req_data;
    assign bus.busy   = (state != ST_IDLE);

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic rd_pend;

    assign reject = accept && (req_op == OP_RD_DATA) && !rd_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            bus.err <= reject;
            if (state == ST_SHIFT && cnt == SHIFT_LAST && op_q == OP_RD_ADDR) begin
                rd_pend <= 1'b1;
            end else if (accept && req_op == OP_RD_DATA) begin
                rd_pend <= 1'b0;
            end
        end
    end
`else
    assign reject  = 1'b0;
    assign bus.err = 1'b0;
`endif

    spi_master_shreg u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (frame_load),
        .shift   ((state == ST_SHIFT) && (cnt != SHIFT_LAST)),
        .clear   ((state == ST_SHIFT) && (cnt == SHIFT_LAST)),
        .capture (state == ST_RECV),
        .frame   (build_frame(req_op, payload)),
        .miso    (MISO),
        .mosi    (MOSI),
        .rx_next (rx_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            op_q          <= OP_WR_ADDR;
            SS_n          <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                ST_SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        cnt <= '0;
                        if (op_q == OP_RD_DATA) begin
                            state <= ST_TURN;
                        end else begin
                            state <= ST_GAP;
                            SS_n  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_TURN: begin
                    if (cnt == TURN_LAST) begin
                        cnt   <= '0;
                        state <= ST_RECV;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_RECV: begin
                    if (cnt == RECV_LAST) begin
                        cnt           <= '0;
                        state         <= ST_GAP;
                        SS_n          <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= rx_next;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    if (frame_load) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        SS_n  <= 1'b0;
                        op_q  <= req_op;
                    end else if (state == ST_GAP) begin
                        if (gap_done) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_seq.sv
// tb/tb_spi_master_seq.sv - randomized bench for spi_master_seq against a per-cycle expected-waveform model
module tb_spi_master_seq;
    import spi_master_seq_pkg::*;

    localparam int MAXC    = 8000;
    localparam int RD_TURN = 2;
    localparam int GAP     = 1;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    localparam bit CHECK_MODE = 1'b1;
`else
    localparam bit CHECK_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic MISO = 1'b0;
    logic SS_n;
    logic MOSI;

    spi_master_seq_if bus();

    spi_master_seq #(.RD_TURN(RD_TURN), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for every cycle, filled in ahead of time as requests are accepted.
    bit         e_ss[MAXC], e_mosi[MAXC], e_busy[MAXC], e_ready[MAXC], e_rspv[MAXC], e_err[MAXC], e_miso[MAXC];
    logic [7:0] e_rspd[MAXC];
    bit         h_ss[MAXC], h_rspv[MAXC], h_err[MAXC], h_mosi[MAXC];
    logic [7:0] h_rspd[MAXC];

    int errors = 0;
    int checks = 0;
    int free_c = 0;
    bit rd_flag = 1'b0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int c);
        for (int k = c; k < MAXC; k++) begin
            e_ss[k] = 1'b1; e_mosi[k] = 1'b0; e_busy[k] = 1'b0; e_ready[k] = 1'b1;
            e_rspv[k] = 1'b0; e_err[k] = 1'b0; e_rspd[k] = 8'h00;
            e_miso[k] = 1'($urandom_range(0, 1));
        end
        rd_flag = 1'b0;
        free_c  = c;
    endtask

    // Request accepted at the edge ending cycle a: frame occupies cycles a+1 .. a+L.
    task automatic plan(input int a, input int op, input int data, input int rb);
        int L, d;
        int bits[11];
        if (CHECK_MODE && op == 3 && !rd_flag) begin
            e_err[a+1] = 1'b1;
            free_c = a + 1;
            return;
        end
        L = (op == 3) ? 11 + RD_TURN + 8 : 11;
        d = (op == 3) ? 0 : (data & 255);
        bits[0] = (op >> 1) & 1;
        bits[1] = (op >> 1) & 1;
        bits[2] = op & 1;
        for (int i = 0; i < 8; i++) bits[3+i] = (d >> (7 - i)) & 1;
        for (int k = 0; k < L; k++) begin
            e_ss[a+1+k] = 1'b0; e_busy[a+1+k] = 1'b1; e_ready[a+1+k] = 1'b0;
            e_mosi[a+1+k] = (k < 11) ? 1'(bits[k]) : 1'b0;
        end
        for (int g = 0; g < GAP; g++) begin
            e_busy[a+1+L+g] = 1'b1;
            e_ready[a+1+L+g] = (g == GAP - 1);
        end
        if (op == 3) begin
            e_rspv[a+1+L] = 1'b1;
            for (int k = a + 1 + L; k < MAXC; k++) e_rspd[k] = 8'(rb);
            for (int i = 0; i < 8; i++) e_miso[a+1+11+RD_TURN+i] = 1'((rb >> (7 - i)) & 1);
        end
        if (op == 2) rd_flag = 1'b1;
        if (op == 3) rd_flag = 1'b0;
        free_c = a + L + GAP;
    endtask

    task automatic send(input int op, input int data, input int rb, output int acc);
        bus.req_valid = 1'b1;
        bus.req_op    = op[1:0];
        bus.req_data  = data[7:0];
        while (cyc < free_c) @(negedge clk);
        acc = cyc;
        plan(acc, op, data, rb);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_data  = 8'($urandom);
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) MISO = e_miso[cyc];
    end

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            h_ss[cyc]   <= SS_n;
            h_mosi[cyc] <= MOSI;
            h_rspv[cyc] <= bus.rsp_valid;
            h_rspd[cyc] <= bus.rsp_data;
            h_err[cyc]  <= bus.err;
            if (chk_en) begin
                check("ss_n",      32'(SS_n),          32'(e_ss[cyc]));
                check("mosi",      32'(MOSI),          32'(e_mosi[cyc]));
                check("busy",      32'(bus.busy),      32'(e_busy[cyc]));
                check("req_ready", 32'(bus.req_ready), 32'(e_ready[cyc]));
                check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rspv[cyc]));
                check("rsp_data",  32'(bus.rsp_data),  32'(e_rspd[cyc]));
                check("err",       32'(bus.err),       32'(e_err[cyc]));
            end
        end
    end

    initial begin
        int a, a1, a2, v, n;
        model_reset(0);
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 32'(bus.req_ready), 0);
        check("reset_ss_n",  32'(SS_n), 1);
        check("reset_mosi",  32'(MOSI), 0);
        check("reset_rspv",  32'(bus.rsp_valid), 0);
        check("reset_rspd",  32'(bus.rsp_data), 0);
        check("reset_err",   32'(bus.err), 0);
        check("reset_busy",  32'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(cyc);
        #1 check("ready_after_release", 32'(bus.req_ready), 1);
        @(negedge clk);
        chk_en = 1'b1;

        // RD_DATA first after reset
        send(3, 8'hFF, 8'h66, a);
        repeat (30) @(negedge clk);
        n = 0;
        for (int c = a; c <= a + 25; c++) n += (h_ss[c] == 1'b0);
        check("first_rd_data_ss_low", n, CHECK_MODE ? 0 : 21);
        check("first_rd_data_err", 32'(h_err[a+1]), CHECK_MODE ? 1 : 0);

        // WR_ADDR 0x3C framing
        send(0, 8'h3C, 0, a);
        repeat (14) @(negedge clk);
        v = 0; n = 0;
        for (int k = 0; k < 11; k++) v = v * 2 + int'(h_mosi[a+1+k]);
        for (int c = a + 1; c <= a + 12; c++) n += (h_ss[c] == 1'b0);
        check("wr_addr_mosi_bits", v, 32'h03C);
        check("wr_addr_ss_low", n, 11);
        check("wr_addr_gap_ss", 32'(h_ss[a+12]), 1);

        // RD_ADDR 0x10 then RD_DATA returning 0xA5
        send(2, 8'h10, 0, a);
        send(3, 8'h00, 8'hA5, a);
        repeat (30) @(negedge clk);
        n = 0;
        for (int c = a; c <= a + 30; c++) n += int'(h_rspv[c]);
        check("rd_rsp_count", n, 1);
        check("rd_rsp_at_22", 32'(h_rspv[a+22]), 1);
        check("rd_rsp_data", 32'(h_rspd[a+22]), 32'hA5);

        // Back-to-back writes with req_valid held
        send(0, int'($urandom_range(0, 255)), 0, a1);
        send(1, int'($urandom_range(0, 255)), 0, a2);
        repeat (14) @(negedge clk);
        n = 0;
        for (int c = a1 + 1; c <= a2 + 11; c++) n += int'(h_ss[c]);
        check("b2b_ss_high", n, GAP);

        for (int i = 0; i < 150 && cyc < MAXC - 200; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), a);
        end

        // Reset during bit 5 of SHIFT after a completed RD_ADDR
        send(2, 8'h22, 0, a);
        repeat (25) @(negedge clk);
        send(0, 8'h96, 0, a);
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ss_n",  32'(SS_n), 1);
        check("midrst_mosi",  32'(MOSI), 0);
        check("midrst_rspv",  32'(bus.rsp_valid), 0);
        check("midrst_busy",  32'(bus.busy), 0);
        check("midrst_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(cyc);
        #1 check("midrst_ready_after", 32'(bus.req_ready), 1);
        @(negedge clk);
        chk_en = 1'b1;
        send(3, 0, 8'h5A, a);
        repeat (30) @(negedge clk);
        n = 0;
        for (int c = a; c <= a + 30; c++) n += int'(h_rspv[c]);
        check("post_rst_rd_err", 32'(h_err[a+1]), CHECK_MODE ? 1 : 0);
        check("post_rst_rsp_count", n, CHECK_MODE ? 0 : 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
